// File: rtl/hex_field_serializer.sv
// Formats NUM_FIELDS latched hex values as "0x<digits>" fields separated by single spaces,
// emitted one ASCII character per valid/ready handshake.
module hex_field_serializer #(
  parameter int NUM_FIELDS = 3,
  parameter int DIGITS     = 2,
  parameter bit UPPERCASE  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_FIELDS*DIGITS*4-1:0] data_in,
  output logic                           busy,
  output logic [7:0]                     char_out,
  output logic                           char_valid,
  input  logic                           char_ready,
  output logic                           char_last,
  output logic                           done
);

  localparam int W  = NUM_FIELDS * DIGITS * 4;
  localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [FW-1:0] LAST_FIELD = FW'(NUM_FIELDS - 1);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

  typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIG, SEP, FIN} state_t;

  state_t        state;
  logic [FW-1:0] field;
  logic [DW-1:0] digit;
  logic [W-1:0]  data_q;
  logic [W-1:0]  data_shift;
  logic          hs;

  // Handshake: a character transfers on a rising edge where char_valid & char_ready are both high.
  assign hs         = char_valid & char_ready;
  // The latch shifts left per emitted digit, so the current digit is always the top nibble.
  assign data_shift = data_q << 4;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      field      <= '0;
      digit      <= '0;
      data_q     <= '0;
      busy       <= 1'b0;
      char_out   <= 8'h00;
      char_valid <= 1'b0;
      char_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state      <= PFX0;
            data_q     <= data_in;
            field      <= '0;
            digit      <= '0;
            busy       <= 1'b1;
            char_valid <= 1'b1;
            char_out   <= 8'h30;
            char_last  <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        PFX0: if (hs) begin
          state    <= PFX1;
          char_out <= 8'h78;
        end
        PFX1: if (hs) begin
          state     <= DIG;
          char_out  <= hex_char(data_q[W-1 -: 4]);
          char_last <= (field == LAST_FIELD) && (DIGITS == 1);
        end
        DIG: if (hs) begin
          data_q <= data_shift;
          if (digit == LAST_DIGIT) begin
            digit <= '0;
            if (field == LAST_FIELD) begin
              state      <= FIN;
              busy       <= 1'b0;
              char_valid <= 1'b0;
              char_last  <= 1'b0;
              char_out   <= 8'h00;
              done       <= 1'b1;
            end else begin
              state    <= SEP;
              field    <= field + 1'b1;
              char_out <= 8'h20;
            end
          end else begin
            digit     <= digit + 1'b1;
            char_out  <= hex_char(data_shift[W-1 -: 4]);
            char_last <= (field == LAST_FIELD) && (digit == DW'(DIGITS - 2));
          end
        end
        SEP: if (hs) begin
          state    <= PFX0;
          char_out <= 8'h30;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_field_serializer.sv
// Directed bench for hex_field_serializer: default-parameter streams from a vector table plus
// hand-written reset, chained-start and single-field lowercase sequences.
module tb_hex_field_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] data_in;
  logic        busy, char_valid, char_ready, char_last, done;
  logic [7:0]  char_out;

  logic        start2, ready2, busy2, valid2, last2, done2;
  logic [15:0] data2;
  logic [7:0]  char2;

  logic [7:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hex_field_serializer u_dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .busy(busy),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .char_last(char_last), .done(done)
  );

  hex_field_serializer #(.NUM_FIELDS(1), .DIGITS(4), .UPPERCASE(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .data_in(data2), .busy(busy2),
    .char_out(char2), .char_valid(valid2), .char_ready(ready2),
    .char_last(last2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_stream(input logic [23:0] d, input logic [111:0] exp, input bit rnd,
                            input int inject_at);
    int hs = 0;
    bit stall = 0;
    bit fin = 0;
    logic [7:0] sc;
    logic sl;
    logic [7:0] e;
    for (int i = 0; i < 14; i++) exp_q.push_back(exp[111-8*i -: 8]);
    start = 1'b1;
    data_in = d;
    @(negedge clk);
    start = 1'b0;
    data_in = 24'h0;
    check("first_valid", char_valid, 1);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (char_valid) begin
        if (stall) begin
          check("stall_char", char_out, sc);
          check("stall_last", char_last, sl);
        end
        check("busy_high", busy, 1);
        if (cyc == inject_at) begin
          start = 1'b1;
          data_in = 24'h555555;
        end else begin
          start = 1'b0;
        end
        char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (char_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check("char", char_out, e);
          check("char_last", char_last, exp_q.size() == 0);
          hs++;
          stall = 0;
        end else begin
          stall = 1;
          sc = char_out;
          sl = char_last;
        end
      end else begin
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_low_with_done", busy, 0);
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) check("stream_timeout", 0, 1);
    check("hs_count", hs, 14);
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    char_ready = 1'b1;
  endtask

  typedef struct {
    logic [23:0]  data;
    logic [111:0] exp;
    bit           rnd;
    int           inject_at;
  } vec_t;

  vec_t vecs[5];
  logic [47:0] beef_exp;
  int spaces;

  initial begin
    vecs[0] = '{24'h3A1FC7, "0x3A 0x1F 0xC7", 1'b0, -1};
    vecs[1] = '{24'h000000, "0x00 0x00 0x00", 1'b0, -1};
    vecs[2] = '{24'hFF09E5, "0xFF 0x09 0xE5", 1'b0, -1};
    vecs[3] = '{24'h3A1FC7, "0x3A 0x1F 0xC7", 1'b1, -1};
    vecs[4] = '{24'h123456, "0x12 0x34 0x56", 1'b0, 4};
    beef_exp = "0xbeef";

    rst = 1'b1; start = 1'b0; data_in = '0; char_ready = 1'b0;
    start2 = 1'b0; data2 = '0; ready2 = 1'b0;
    #1;
    check("rst_valid", char_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", char_last, 0);
    check("rst_char", char_out, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_stream(vecs[v].data, vecs[v].exp, vecs[v].rnd, vecs[v].inject_at);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_valid", char_valid, 0);
    end

    // Start issued in the done cycle must be accepted with no extra idle cycle.
    run_stream(24'h3A1FC7, "0x3A 0x1F 0xC7", 1'b0, -1);
    run_stream(24'hABCDEF, "0xAB 0xCD 0xEF", 1'b0, -1);
    @(negedge clk);
    check("chain_done_one_cycle", done, 0);

    // Asynchronous reset mid-stream after five handshakes.
    start = 1'b1; data_in = 24'h3A1FC7; char_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", char_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_char", char_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_no_done", done, 0);
    check("arst_idle", char_valid, 0);
    run_stream(24'h3A1FC7, "0x3A 0x1F 0xC7", 1'b0, -1);
    @(negedge clk);

    // Single-field, four-digit, lowercase instance.
    spaces = 0;
    data2 = 16'hBEEF; start2 = 1'b1; ready2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; data2 = 16'h0;
    for (int i = 0; i < 6; i++) begin
      check("beef_valid", valid2, 1);
      check("beef_char", char2, beef_exp[47-8*i -: 8]);
      check("beef_last", last2, i == 5);
      if (char2 == 8'h20) spaces++;
      @(negedge clk);
    end
    check("beef_no_space", spaces, 0);
    check("beef_done", done2, 1);
    check("beef_valid_low", valid2, 0);
    check("beef_busy_low", busy2, 0);
    @(negedge clk);
    check("beef_done_one_cycle", done2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
